// File: rtl/compressor_pkg.sv
// compressor_pkg: shared constants and full-adder helper functions for the
// Booth-4 / Wallace-tree multiplier reduction cells.
package compressor_pkg;

   localparam int DEFAULT_WIDTH = 1;
   localparam int MULT_COLUMNS  = 32;

   function automatic logic parity3(input logic a, input logic b, input logic c);
      return a ^ b ^ c;
   endfunction

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (c & (a ^ b));
   endfunction

endpackage

// File: rtl/fa_cell.sv
// fa_cell: single-bit full adder, the per-column reduction cell of a 3:2 compressor.
module fa_cell
   import compressor_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = parity3(a, b, cin);
   assign cout = maj3(a, b, cin);

endmodule

// File: rtl/compressor_3_2.sv
// compressor_3_2: row of independent full adders with an optional output stage.
// Define COMPRESSOR_3_2_OUTREG_EN for the registered build; otherwise purely combinational.
module compressor_3_2
   import compressor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic [WIDTH-1:0] ci,
   output logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] co,
   output logic             out_valid
);

   logic [WIDTH-1:0] w_d;
   logic [WIDTH-1:0] w_co;

   // co stays at column weight; the consumer applies the one-bit shift
   for (genvar k = 0; k < WIDTH; k++) begin : g_col
      fa_cell u_fa (
         .a    (i0[k]),
         .b    (i1[k]),
         .cin  (ci[k]),
         .s    (w_d[k]),
         .cout (w_co[k])
      );
   end

`ifdef COMPRESSOR_3_2_OUTREG_EN
   logic [WIDTH-1:0] r_d;
   logic [WIDTH-1:0] r_co;
   logic             r_valid;

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_d     <= '0;
         r_co    <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_d  <= w_d;
            r_co <= w_co;
         end
      end
   end

   assign d         = r_d;
   assign co        = r_co;
   assign out_valid = r_valid;
`else
   logic w_unused;

   assign w_unused  = &{1'b0, sys_clk, sys_rst_n};
   assign d         = w_d;
   assign co        = w_co;
   assign out_valid = in_valid;
`endif

endmodule

// File: tb/tb_compressor_3_2.sv
// tb_compressor_3_2: randomized scoreboard bench; follows COMPRESSOR_3_2_OUTREG_EN
// to pick the registered (1-cycle) or combinational (0-cycle) expectation.
module tb_compressor_3_2;

   localparam int W = 16;

`ifdef COMPRESSOR_3_2_OUTREG_EN
   localparam bit REG = 1'b1;
`else
   localparam bit REG = 1'b0;
`endif

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] c;
      logic [W-1:0] d;
      logic [W-1:0] co;
   } exp_t;

   logic         sys_clk = 1'b0;
   logic         sys_rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic [W-1:0] i0 = '0;
   logic [W-1:0] i1 = '0;
   logic [W-1:0] ci = '0;
   logic [W-1:0] d;
   logic [W-1:0] co;
   logic         out_valid;

   exp_t         exp_q[$];
   logic [W-1:0] held_d = '0;
   logic [W-1:0] held_co = '0;
   int           n_cmp = 0;
   int           n_bad = 0;

   compressor_3_2 #(.WIDTH(W)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .in_valid  (in_valid),
      .i0        (i0),
      .i1        (i1),
      .ci        (ci),
      .d         (d),
      .co        (co),
      .out_valid (out_valid)
   );

   always #5 sys_clk = ~sys_clk;

   // Reference: count the ones in each column; the count is 2*carry + sum.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] c);
      exp_t e;
      e.a = a;
      e.b = b;
      e.c = c;
      for (int k = 0; k < W; k++) begin
         int cnt;
         cnt = int'(a[k]) + int'(b[k]) + int'(c[k]);
         e.d[k]  = (cnt % 2) == 1;
         e.co[k] = cnt >= 2;
      end
      return e;
   endfunction

   task automatic check(input string name, input logic [W:0] act, input logic [W:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic drive(input logic rst_n, input logic v, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] c);
      @(negedge sys_clk);
      sys_rst_n = rst_n;
      in_valid  = v;
      i0 = a;
      i1 = b;
      ci = c;
      if (v && (rst_n || !REG)) exp_q.push_back(model(a, b, c));
   endtask

   always @(posedge sys_clk) begin
      exp_t e;
      #1;
      if (REG && !sys_rst_n) begin
         exp_q.delete();
         held_d  = '0;
         held_co = '0;
      end
      if (!REG) check("out_valid", {{W{1'b0}}, out_valid}, {{W{1'b0}}, in_valid});
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            check("spurious_valid", {{W{1'b0}}, out_valid}, '0);
         end else begin
            e = exp_q.pop_front();
            check("d", {1'b0, d}, {1'b0, e.d});
            check("co", {1'b0, co}, {1'b0, e.co});
            check("invariant", {1'b0, d} + {co, 1'b0},
                  {1'b0, e.a} + {1'b0, e.b} + {1'b0, e.c});
            held_d  = e.d;
            held_co = e.co;
         end
      end else if (REG) begin
         check("hold_d", {1'b0, d}, {1'b0, held_d});
         check("hold_co", {1'b0, co}, {1'b0, held_co});
      end else begin
         e = model(i0, i1, ci);
         check("comb_d", {1'b0, d}, {1'b0, e.d});
         check("comb_co", {1'b0, co}, {1'b0, e.co});
      end
   end

   initial begin
      logic [W-1:0] ones;
      ones = '1;
      drive(1'b0, 1'b0, '0, '0, '0);
      drive(1'b0, 1'b0, '0, '0, '0);
      for (int c = 0; c < 2; c++)
         for (int s = 0; s < 4; s++)
            drive(1'b1, 1'b1, W'(s & 1), W'(s >> 1), W'(c));
      drive(1'b1, 1'b1, 16'h00FF, 16'h0001, 16'h0000);
      drive(1'b1, 1'b1, 16'h1234, 16'hABCD, 16'h0F0F);
      drive(1'b1, 1'b0, 16'hFFFF, 16'h5555, 16'hAAAA);
      drive(1'b1, 1'b0, 16'h0F0F, 16'hF0F0, 16'h3333);
      drive(1'b0, 1'b1, ones, ones, ones);
      drive(1'b1, 1'b0, 16'h7777, 16'h1111, 16'h2222);
      drive(1'b1, 1'b1, 16'h8001, 16'h8001, 16'h0001);
      for (int n = 0; n < 1000; n++)
         drive(1'b1, $urandom_range(0, 3) != 0, W'($urandom), W'($urandom), W'($urandom));
      drive(1'b1, 1'b0, '0, '0, '0);
      drive(1'b1, 1'b0, '0, '0, '0);
      check("queue_drained", (W + 1)'(exp_q.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
